// File: rtl/mmio_arbiter_pkg.sv
// Shared types and constants for the MMIO bus arbiter and its requester interface.
package mmio_pkg;

  localparam int          MMIO_DATA_WIDTH = 8;
  localparam logic [31:0] MMIO_GPIO_BASE  = 32'h2000_0000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } mmio_arb_state_e;

  // Winner's captured request plus the precomputed window check.
  typedef struct packed {
    logic                       we;
    logic [31:0]                addr;
    logic [MMIO_DATA_WIDTH-1:0] wdata;
    logic                       in_win;
  } mmio_hold_t;

  // Subtract only after the lower-bound test so a window ending at 2^32 never wraps.
  function automatic logic mmio_in_window(input logic [31:0] addr,
                                          input logic [31:0] base,
                                          input logic [31:0] span);
    return (addr >= base) && ((addr - base) < span);
  endfunction

endpackage

// File: rtl/mmio_arbiter_if.sv
// Requester handshake plus MMIO peripheral bus; master = requesters/peripherals, slave = arbiter.
interface mmio_arbiter_if
  import mmio_pkg::*;
#(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]                      i_req;
  logic [NUM_REQ-1:0]                      i_we;
  logic [NUM_REQ-1:0][31:0]                i_addr;
  logic [NUM_REQ-1:0][MMIO_DATA_WIDTH-1:0] i_wdata;
  logic [NUM_REQ-1:0]                      o_gnt;
  logic [NUM_REQ-1:0]                      o_ack;
  logic [MMIO_DATA_WIDTH-1:0]              o_rdata;
  logic                                    o_err;

  logic [31:0]                             o_mmio_addr;
  logic [MMIO_DATA_WIDTH-1:0]              o_mmio_data_in;
  logic                                    o_mmio_we;
  logic                                    o_mmio_re;
  logic [MMIO_DATA_WIDTH-1:0]              i_mmio_data_out;

  modport master (
    output i_req, i_we, i_addr, i_wdata, i_mmio_data_out,
    input  o_gnt, o_ack, o_rdata, o_err,
           o_mmio_addr, o_mmio_data_in, o_mmio_we, o_mmio_re
  );

  modport slave (
    input  i_req, i_we, i_addr, i_wdata, i_mmio_data_out,
    output o_gnt, o_ack, o_rdata, o_err,
           o_mmio_addr, o_mmio_data_in, o_mmio_we, o_mmio_re
  );
endinterface

// File: rtl/mmio_rr_pick.sv
// Combinational one-hot winner pick; search starts after i_last when RR_EN, else at index 0.
module mmio_rr_pick #(
  parameter int  N     = 2,
  parameter bit  RR_EN = 1'b1,
  localparam int IW    = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_last,
  output logic [N-1:0]  o_onehot,
  output logic [IW-1:0] o_idx
);

  logic [IW-1:0] w_start;
  logic [IW-1:0] w_cand [N];
  logic          w_found;

  // Candidate order: start, start+1, ... modulo N (N need not be a power of two).
  always_comb begin
    w_start = '0;
    if (RR_EN)
      w_start = (int'(i_last) == N-1) ? '0 : i_last + 1'b1;
    for (int k = 0; k < N; k++)
      w_cand[k] = IW'((int'(w_start) + k) % N);
  end

  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    w_found  = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!w_found && i_req[w_cand[k]]) begin
        o_onehot[w_cand[k]] = 1'b1;
        o_idx               = w_cand[k];
        w_found             = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mmio_arbiter.sv
// NUM_REQ-way arbiter onto the 8-bit MMIO bus: IDLE -> ACCESS -> RESP, one beat per grant.
// Define MMIO_ARB_ROUND_ROBIN_EN for round-robin selection; default is fixed lowest-index priority.
module mmio_arbiter
  import mmio_pkg::*;
#(
  parameter int          NUM_REQ   = 2,
  parameter logic [31:0] BASE_ADDR = MMIO_GPIO_BASE,
  parameter logic [31:0] SPAN      = 32'h0000_1000
) (
  input logic            i_clk,
  input logic            i_rstn,
  mmio_arbiter_if.slave  bus
);

  localparam int IW = $clog2(NUM_REQ);

  mmio_arb_state_e            r_state, w_state_nxt;
  mmio_hold_t                 r_hold;
  logic [IW-1:0]              r_win;
  logic [MMIO_DATA_WIDTH-1:0] r_rdata;

  logic [NUM_REQ-1:0]         w_pick;
  logic [IW-1:0]              w_idx;
  logic                       w_any;
  logic                       w_sel_we;
  logic [31:0]                w_sel_addr;
  logic [MMIO_DATA_WIDTH-1:0] w_sel_wdata;
  logic [NUM_REQ-1:0]         w_win_oh;
  logic                       w_accept;

  assign w_any    = |bus.i_req;
  assign w_accept = (r_state == IDLE) && w_any;

`ifdef MMIO_ARB_ROUND_ROBIN_EN
  logic [IW-1:0] r_last;

  // Reset value NUM_REQ-1 makes requester 0 the first candidate.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn)       r_last <= IW'(NUM_REQ-1);
    else if (w_accept) r_last <= w_idx;
  end

  mmio_rr_pick #(.N(NUM_REQ), .RR_EN(1'b1)) u_pick (
    .i_req    (bus.i_req),
    .i_last   (r_last),
    .o_onehot (w_pick),
    .o_idx    (w_idx)
  );
`else
  mmio_rr_pick #(.N(NUM_REQ), .RR_EN(1'b0)) u_pick (
    .i_req    (bus.i_req),
    .i_last   ('0),
    .o_onehot (w_pick),
    .o_idx    (w_idx)
  );
`endif

  // One-hot AND-OR mux of the winner's fields.
  always_comb begin
    w_sel_we    = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_pick[k]) begin
        w_sel_we    = bus.i_we[k];
        w_sel_addr  = bus.i_addr[k];
        w_sel_wdata = bus.i_wdata[k];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_any) w_state_nxt = ACCESS;
      ACCESS:  w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_hold  <= '0;
      r_win   <= '0;
      r_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_hold <= '{we:     w_sel_we,
                    addr:   w_sel_addr,
                    wdata:  w_sel_wdata,
                    in_win: mmio_in_window(w_sel_addr, BASE_ADDR, SPAN)};
        r_win  <= w_idx;
      end
      // Only a strobed read returns peripheral data; writes and range errors return zero.
      if (r_state == ACCESS)
        r_rdata <= (r_hold.in_win && !r_hold.we) ? bus.i_mmio_data_out : '0;
    end
  end

  assign w_win_oh = NUM_REQ'(1) << r_win;

  assign bus.o_gnt          = (r_state == ACCESS) ? w_win_oh     : '0;
  assign bus.o_mmio_addr    = (r_state == ACCESS) ? r_hold.addr  : '0;
  assign bus.o_mmio_data_in = (r_state == ACCESS) ? r_hold.wdata : '0;
  assign bus.o_mmio_we      = (r_state == ACCESS) && r_hold.in_win &&  r_hold.we;
  assign bus.o_mmio_re      = (r_state == ACCESS) && r_hold.in_win && !r_hold.we;

  assign bus.o_ack          = (r_state == RESP) ? w_win_oh : '0;
  assign bus.o_err          = (r_state == RESP) && !r_hold.in_win;
  assign bus.o_rdata        = (r_state == RESP) ? r_rdata  : '0;

endmodule

// File: tb/tb_mmio_arbiter.sv
// Directed bench for mmio_arbiter: vector table plus reset, back-to-back and wrap-edge sequences.
module tb_mmio_arbiter;

`ifdef MMIO_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstn;
  logic [7:0] gpio;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mmio_arbiter_if #(.NUM_REQ(2)) ifa ();
  mmio_arbiter_if #(.NUM_REQ(2)) ifb ();

  mmio_arbiter #(.NUM_REQ(2), .BASE_ADDR(32'h2000_0000), .SPAN(32'h0000_1000)) dut_a (
    .i_clk (clk), .i_rstn (rstn), .bus (ifa.slave)
  );

  mmio_arbiter #(.NUM_REQ(2), .BASE_ADDR(32'hFFFF_F000), .SPAN(32'h0000_1000)) dut_b (
    .i_clk (clk), .i_rstn (rstn), .bus (ifb.slave)
  );

  // GPIO model: one register, written on a write strobe, read combinationally.
  always_ff @(posedge clk) if (ifa.o_mmio_we) gpio <= ifa.o_mmio_data_in;
  assign ifa.i_mmio_data_out = gpio;
  assign ifb.i_mmio_data_out = 8'h5A;

  typedef struct {
    logic [1:0]  req, we;
    logic [31:0] a0;  logic [7:0] d0;
    logic [31:0] a1;  logic [7:0] d1;
    logic [1:0]  gnt;
    logic        mwe, mre;
    logic [31:0] maddr; logic [7:0] mdata;
    logic        err;   logic [7:0] rdata;
  } vec_t;

  vec_t vt [8];

  function automatic vec_t mk(logic [1:0] req, logic [1:0] we,
                              logic [31:0] a0, logic [7:0] d0, logic [31:0] a1, logic [7:0] d1,
                              logic [1:0] gnt, logic mwe, logic mre, logic [31:0] maddr,
                              logic [7:0] mdata, logic err, logic [7:0] rdata);
    vec_t v;
    v.req = req; v.we = we; v.a0 = a0; v.d0 = d0; v.a1 = a1; v.d1 = d1;
    v.gnt = gnt; v.mwe = mwe; v.mre = mre; v.maddr = maddr; v.mdata = mdata;
    v.err = err; v.rdata = rdata;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Issue in IDLE, check ACCESS at N+1 and RESP at N+2, return in IDLE.
  task automatic run_vec(input vec_t v, input int id);
    ifa.i_req = v.req; ifa.i_we = v.we;
    ifa.i_addr[0] = v.a0; ifa.i_wdata[0] = v.d0;
    ifa.i_addr[1] = v.a1; ifa.i_wdata[1] = v.d1;
    @(posedge clk); #1;
    chk($sformatf("v%0d gnt", id),   32'(ifa.o_gnt), 32'(v.gnt));
    chk($sformatf("v%0d we", id),    32'(ifa.o_mmio_we), 32'(v.mwe));
    chk($sformatf("v%0d re", id),    32'(ifa.o_mmio_re), 32'(v.mre));
    chk($sformatf("v%0d maddr", id), ifa.o_mmio_addr, v.maddr);
    chk($sformatf("v%0d mdata", id), 32'(ifa.o_mmio_data_in), 32'(v.mdata));
    chk($sformatf("v%0d ack_early", id), 32'(ifa.o_ack), 32'd0);
    ifa.i_req = '0;
    @(posedge clk); #1;
    chk($sformatf("v%0d ack", id),   32'(ifa.o_ack), 32'(v.gnt));
    chk($sformatf("v%0d err", id),   32'(ifa.o_err), 32'(v.err));
    chk($sformatf("v%0d rdata", id), 32'(ifa.o_rdata), 32'(v.rdata));
    chk($sformatf("v%0d strobe_off", id), 32'({ifa.o_mmio_we, ifa.o_mmio_re}), 32'd0);
    @(posedge clk); #1;
    chk($sformatf("v%0d idle", id),  32'({ifa.o_ack, ifa.o_gnt}), 32'd0);
  endtask

  logic [7:0] gpio_exp;
  logic [1:0] exp_g;
  logic [31:0] b_addr [3];
  logic        b_err  [3];

  initial begin
    vt[0] = mk(2'b01, 2'b01, 32'h2000_0000, 8'hA5, 32'h0, 8'h00,
               2'b01, 1'b1, 1'b0, 32'h2000_0000, 8'hA5, 1'b0, 8'h00);
    vt[1] = mk(2'b10, 2'b00, 32'h0, 8'h00, 32'h2000_0000, 8'h3C,
               2'b10, 1'b0, 1'b1, 32'h2000_0000, 8'h3C, 1'b0, 8'hA5);
    vt[2] = mk(2'b01, 2'b00, 32'h1FFF_FFFF, 8'h00, 32'h0, 8'h00,
               2'b01, 1'b0, 1'b0, 32'h1FFF_FFFF, 8'h00, 1'b1, 8'h00);
    vt[3] = mk(2'b10, 2'b00, 32'h0, 8'h00, 32'h2000_1000, 8'h00,
               2'b10, 1'b0, 1'b0, 32'h2000_1000, 8'h00, 1'b1, 8'h00);
    vt[4] = mk(2'b01, 2'b01, 32'h2000_0FFF, 8'h5C, 32'h0, 8'h00,
               2'b01, 1'b1, 1'b0, 32'h2000_0FFF, 8'h5C, 1'b0, 8'h00);
    // Last winner is 0 here: round-robin picks 1, fixed priority picks 0.
    vt[5] = mk(2'b11, 2'b11, 32'h2000_0004, 8'h11, 32'h2000_0008, 8'h22,
               RR ? 2'b10 : 2'b01, 1'b1, 1'b0, RR ? 32'h2000_0008 : 32'h2000_0004,
               RR ? 8'h22 : 8'h11, 1'b0, 8'h00);
    vt[6] = mk(2'b01, 2'b00, 32'h2000_0000, 8'h00, 32'h0, 8'h00,
               2'b01, 1'b0, 1'b1, 32'h2000_0000, 8'h00, 1'b0, RR ? 8'h22 : 8'h11);
    vt[7] = mk(2'b11, 2'b00, 32'h2000_0010, 8'h00, 32'h2000_0020, 8'h00,
               RR ? 2'b10 : 2'b01, 1'b0, 1'b1, RR ? 32'h2000_0020 : 32'h2000_0010,
               8'h00, 1'b0, RR ? 8'h22 : 8'h11);

    rstn = 1'b0;
    ifa.i_req = '0; ifa.i_we = '0; ifa.i_addr = '0; ifa.i_wdata = '0;
    ifb.i_req = '0; ifb.i_we = '0; ifb.i_addr = '0; ifb.i_wdata = '0;
    #12;
    chk("reset gnt_ack_err", 32'({ifa.o_gnt, ifa.o_ack, ifa.o_err}), 32'd0);
    chk("reset mmio", 32'({ifa.o_mmio_we, ifa.o_mmio_re, ifa.o_mmio_data_in}), 32'd0);
    chk("reset maddr", ifa.o_mmio_addr, 32'd0);
    chk("reset rdata", 32'(ifa.o_rdata), 32'd0);
    rstn = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      run_vec(vt[i], i);
      if (i == 0) chk("gpio after write", 32'(gpio), 32'hA5);
    end
    gpio_exp = RR ? 8'h22 : 8'h11;

    // Both held across four back-to-back transactions from a fresh pointer.
    rstn = 1'b0; #2; rstn = 1'b1;
    @(posedge clk); #1;
    ifa.i_req = 2'b11; ifa.i_we = 2'b00;
    ifa.i_addr[0] = 32'h2000_0000; ifa.i_addr[1] = 32'h2000_0004;
    for (int t = 0; t < 4; t++) begin
      exp_g = (RR && (t % 2 == 1)) ? 2'b10 : 2'b01;
      @(posedge clk); #1;
      chk($sformatf("b2b%0d gnt", t), 32'(ifa.o_gnt), 32'(exp_g));
      if (t == 3) ifa.i_req = '0;
      @(posedge clk); #1;
      chk($sformatf("b2b%0d ack", t), 32'(ifa.o_ack), 32'(exp_g));
      chk($sformatf("b2b%0d rdata", t), 32'(ifa.o_rdata), 32'(gpio_exp));
      @(posedge clk); #1;
    end
    chk("b2b idle after drop", 32'(ifa.o_gnt), 32'd0);

    // Reset asserted in the middle of ACCESS drops the write with no ack.
    ifa.i_req = 2'b01; ifa.i_we = 2'b01;
    ifa.i_addr[0] = 32'h2000_0000; ifa.i_wdata[0] = 8'h77;
    @(posedge clk); #1;
    chk("rst_mid gnt before", 32'(ifa.o_gnt), 32'(2'b01));
    chk("rst_mid we before", 32'(ifa.o_mmio_we), 32'd1);
    #2 rstn = 1'b0;
    #1;
    chk("rst_mid gnt", 32'(ifa.o_gnt), 32'd0);
    chk("rst_mid strobes", 32'({ifa.o_mmio_we, ifa.o_mmio_re}), 32'd0);
    chk("rst_mid maddr", ifa.o_mmio_addr, 32'd0);
    chk("rst_mid mdata", 32'(ifa.o_mmio_data_in), 32'd0);
    ifa.i_req = '0;
    #2 rstn = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      chk($sformatf("rst_mid no_ack%0d", c), 32'(ifa.o_ack), 32'd0);
    end
    chk("rst_mid gpio kept", 32'(gpio), 32'(gpio_exp));
    run_vec(mk(2'b01, 2'b00, 32'h2000_0000, 8'h00, 32'h0, 8'h00,
               2'b01, 1'b0, 1'b1, 32'h2000_0000, 8'h00, 1'b0, gpio_exp), 100);

    // Window ending exactly at 2^32 on the second instance.
    b_addr[0] = 32'hFFFF_FFFF; b_err[0] = 1'b0;
    b_addr[1] = 32'hFFFF_F000; b_err[1] = 1'b0;
    b_addr[2] = 32'hFFFF_EFFF; b_err[2] = 1'b1;
    for (int j = 0; j < 3; j++) begin
      ifb.i_req = 2'b01; ifb.i_we = 2'b00; ifb.i_addr[0] = b_addr[j];
      @(posedge clk); #1;
      chk($sformatf("wrap%0d re", j), 32'(ifb.o_mmio_re), 32'(!b_err[j]));
      chk($sformatf("wrap%0d maddr", j), ifb.o_mmio_addr, b_addr[j]);
      ifb.i_req = '0;
      @(posedge clk); #1;
      chk($sformatf("wrap%0d ack", j), 32'(ifb.o_ack), 32'(2'b01));
      chk($sformatf("wrap%0d err", j), 32'(ifb.o_err), 32'(b_err[j]));
      chk($sformatf("wrap%0d rdata", j), 32'(ifb.o_rdata), b_err[j] ? 32'h00 : 32'h5A);
      @(posedge clk); #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmio_arbiter.md
# mmio_arbiter

Shares the single 8-bit MMIO peripheral bus (the one driving `gpio_mmio` and later peripherals) between `NUM_REQ` bus masters, e.g. the CPU load/store port and a debug loader. Each requester issues a one-beat read or write using a req/gnt/ack handshake. The arbiter picks one winner, drives the MMIO strobes for exactly one cycle and returns read data plus a range-error flag. It sits between the core's memory-stage address decoder and the MMIO peripheral bus.

## Interface
- `NUM_REQ`, 2: number of requesters (2..8).
- `BASE_ADDR`, 32'h2000_0000: first legal MMIO address.
- `SPAN`, 32'h0000_1000: legal window size in bytes; the window is `[BASE_ADDR, BASE_ADDR+SPAN)`.
- `i_clk`  in  1: clock; all logic is on the rising edge.
- `i_rstn`  in  1: reset. One clock; reset is asynchronous and active-low.
- `i_req`  in  NUM_REQ: per-requester request.
- `i_we`  in  NUM_REQ: 1 = write, 0 = read.
- `i_addr`  in  NUM_REQ x 32: per-requester address.
- `i_wdata`  in  NUM_REQ x 8: per-requester write data.
- `o_gnt`  out  NUM_REQ: one-hot, one-cycle pulse; the request has been captured.
- `o_ack`  out  NUM_REQ: one-hot, one-cycle pulse; the transaction is complete.
- `o_rdata`  out  8: read data, valid while `o_ack` is high.
- `o_err`  out  1: the address was out of window, valid while `o_ack` is high.
- `o_mmio_addr`  out  32: address to the peripheral bus.
- `o_mmio_data_in`  out  8: write data to the peripheral bus.
- `o_mmio_we`  out  1: write strobe.
- `o_mmio_re`  out  1: read strobe.
- `i_mmio_data_out`  in  8: combinational read data from the peripherals.

## Operation
- FSM states are IDLE, ACCESS and RESP.
- IDLE:
  - If any `i_req` is high, select a winner and register its `we`, `addr` and `wdata` into holding registers.
  - Register the in-window flag: `addr >= BASE_ADDR && addr - BASE_ADDR < SPAN`, computed as 32-bit unsigned with no wrap past 2^32.
  - Go to ACCESS.
- ACCESS (exactly one cycle):
  - `o_gnt[winner]`=1.
  - `o_mmio_addr` and `o_mmio_data_in` come from the holding registers.
  - If in window: `o_mmio_we`=latched we and `o_mmio_re`=!we. Otherwise both strobes stay 0.
  - On a read, `i_mmio_data_out` is sampled into the `o_rdata` register.
  - Go to RESP.
- RESP (exactly one cycle):
  - `o_ack[winner]`=1 and `o_err`=!in_window.
  - `o_rdata` = sampled value for an in-window read, else 8'h00.
  - Go to IDLE.
- Requester rules:
  - Hold `i_req` and its fields stable until `o_gnt` is seen.
  - Drop `i_req` in the cycle after `o_gnt` unless a new transaction is being issued.
  - Requests during ACCESS/RESP are ignored, not queued.
- Winner selection is fixed-priority (lowest index) or round-robin; see Configuration.
- Outputs outside their state: `o_mmio_*` are 0 outside ACCESS (address 0 included), and `o_gnt`, `o_ack`, `o_err` are 0 outside their states.
- Reset at any time, including mid-transaction:
  - State goes to IDLE and all outputs go to 0.
  - Holding registers and `o_rdata` clear to 0.
  - RR pointer goes to `NUM_REQ-1`, so requester 0 has first priority.
  - An in-flight transaction is dropped with no ack.

## Timing
- Request high in IDLE at cycle N: `o_gnt` and strobes at N+1, `o_ack`/`o_rdata`/`o_err` at N+2, IDLE at N+3.
- Peak throughput is one transaction per 3 cycles.
- Back-to-back: a request still high in the IDLE cycle at N+3 is accepted in that same cycle.
- All outputs are registered or decoded from registered state and holding registers only.
- The only combinational input path is `i_mmio_data_out` into the `o_rdata` register.

## Configuration
- `MMIO_ARB_ROUND_ROBIN_EN`:
  - When defined, the search starts at `last_winner+1` modulo `NUM_REQ`, and `last_winner` updates on every grant.
  - When undefined, the lowest-index active request always wins and no pointer register is built.

## Structure
- `mmio_pkg` holds:
  - `mmio_arb_state_e` (IDLE, ACCESS, RESP);
  - `MMIO_DATA_WIDTH`=8;
  - `MMIO_GPIO_BASE`=32'h2000_0000.
- Sub-module `mmio_rr_pick` does the combinational one-hot winner selection from the request vector and pointer. It has a parameterised width and a fixed-priority fallback.

## Test plan
- Req0 write addr 0x2000_0000, data 0xA5 -> `o_mmio_we`=1 with data 0xA5 at N+1; `o_ack[0]` at N+2 with `o_err`=0; the GPIO model shows 0xA5.
- Req1 read 0x2000_0000 after the previous write -> `o_mmio_re`=1 at N+1; `o_ack[1]` with `o_rdata`=0xA5 at N+2.
- Out-of-window reads at 0x1FFF_FFFF and 0x2000_1000 -> no strobes; `o_ack` with `o_err`=1 and `o_rdata`=0x00.
- Both requesters held high for 4 transactions:
  - RR defined: grants go 0,1,0,1.
  - RR undefined: grants go 0,0,0,0.
- Req issued, `i_rstn` pulsed low during ACCESS -> all outputs 0 immediately; no `o_ack`; the next request is serviced normally from IDLE.
- Address 0xFFFF_FFFF with BASE_ADDR=0xFFFF_F000 and SPAN=0x1000 -> in window; no wrap error.
